// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers a 4-digit hex value from a multiplexed 7-segment scan
//
// Watches the active-low segment and anode lines of a scanned 4-digit display.
// Each digit dwell is captured once after it has been stable for SETTLE_CYCLES
// consecutive edges. Captures build a frame. When all four digits have been
// seen, the frame is published.
//
// Ports:
//   clk          - the only clock, rising edge
//   rst_n        - synchronous active-low reset
//   seg[6:0]     - active-low segments, bit0=a .. bit6=g
//   an[3:0]      - active-low digit enables, an[i]=0 selects digit i
//   value[15:0]  - last complete frame, digit i in value[4i+3:4i]
//   digit_err[3:0] - digit i of the last frame held an undecodable pattern
//   frame_valid  - one-cycle pulse when value/digit_err update

module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_M1  = 8'(SETTLE_CYCLES - 1);

    typedef enum logic {
        WAIT = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [10:0] prev_sample;
    logic [7:0]  stable_cnt;
    logic [15:0] shadow_val;
    logic [3:0]  shadow_err;
    logic [3:0]  seen;

    logic [10:0] sample;
    logic        same;
    logic [3:0]  digit_sel;
    logic [4:0]  decoded;
    logic        capture;
    logic [15:0] next_val;
    logic [3:0]  next_err;
    logic [3:0]  seen_next;

    // Returns {err, nibble}; unknown patterns decode as nibble 0 with err set.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign sample  = {an, seg};
    assign same    = (sample == prev_sample);
    assign decoded = decode_seg(seg);

    // Only a single low anode names a digit; blanking and multi-digit
    // patterns yield no selection and therefore never capture.
    always_comb begin
        digit_sel = 4'b0000;
        case (an)
            4'b1110: digit_sel = 4'b0001;
            4'b1101: digit_sel = 4'b0010;
            4'b1011: digit_sel = 4'b0100;
            4'b0111: digit_sel = 4'b1000;
            default: digit_sel = 4'b0000;
        endcase
    end

    // stable_cnt counts equal edges before this one, so this edge is the
    // SETTLE_CYCLES-th when the count sits one below the target.
    assign capture = (state == WAIT) && same && (stable_cnt == SETTLE_M1)
                     && (digit_sel != 4'b0000);

    // Shadow contents including this edge's capture, so the publishing edge
    // can copy the final digit straight into value.
    always_comb begin
        next_val = shadow_val;
        next_err = shadow_err;
        for (int i = 0; i < 4; i++) begin
            if (capture && digit_sel[i]) begin
                next_val[4*i +: 4] = decoded[3:0];
                next_err[i]        = decoded[4];
            end
        end
    end

    assign seen_next = seen | (capture ? digit_sel : 4'b0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WAIT;
            prev_sample <= '1;
            stable_cnt  <= '0;
            shadow_val  <= '0;
            shadow_err  <= '0;
            seen        <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            prev_sample <= sample;
            frame_valid <= 1'b0;

            if (!same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != SETTLE_MAX) begin
                stable_cnt <= stable_cnt + 8'd1;
            end

            case (state)
                WAIT: begin
                    if (capture) begin
                        state      <= HOLD;
                        shadow_val <= next_val;
                        shadow_err <= next_err;
                        if (seen_next == 4'hF) begin
                            value       <= next_val;
                            digit_err   <= next_err;
                            frame_valid <= 1'b1;
                            seen        <= 4'h0;
                        end else begin
                            seen <= seen_next;
                        end
                    end
                end
                HOLD: begin
                    // A dwell is captured once; any change re-arms capture.
                    if (!same) begin
                        state <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder

module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    logic prev_fv = 1'b0;

    seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected frame for every frame_valid pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            check("no_back_to_back", {31'd0, prev_fv}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got value %0h at cycle %0d, expected no frame",
                         value, cyc);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("frame_value", {16'd0, value}, {16'd0, x.v});
                check("frame_err", {28'd0, digit_err}, {28'd0, x.e});
                check("frame_cycle", cyc, x.c);
            end
        end
        prev_fv <= frame_valid;
    end

    // Inputs change right after a falling edge and stay for n rising edges.
    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    // Final digit of a frame: its capture edge is the S-th edge after the first
    // edge that samples it, so the pulse is seen at that cycle count.
    task automatic last_dwell(input logic [3:0] a, input logic [6:0] s,
                              input logic [15:0] v, input logic [3:0] e);
        exp_t x;
        x.v = v;
        x.e = e;
        x.c = cyc + 1 + S;
        exp_q.push_back(x);
        dwell(a, s, 8);
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'hE;
        seg   = 7'h79;

        // Outputs stay at reset values despite input activity.
        for (int i = 0; i < 3; i++) begin
            an  = (i == 1) ? 4'hD : 4'hE;
            seg = (i == 2) ? 7'h24 : 7'h79;
            @(negedge clk);
            check("reset_value", {16'd0, value}, 32'd0);
            check("reset_err", {28'd0, digit_err}, 32'd0);
            check("reset_fv", {31'd0, frame_valid}, 32'd0);
        end
        rst_n = 1'b1;
        dwell(4'hF, 7'h7F, 2);

        // Basic scan 1,2,3,4.
        dwell(4'hE, 7'h79, 8);
        dwell(4'hD, 7'h24, 8);
        dwell(4'hB, 7'h30, 8);
        last_dwell(4'h7, 7'h19, 16'h4321, 4'h0);

        // Minimum dwell: S stable edges on digit 0 captures.
        dwell(4'hE, 7'h02, S + 1);
        dwell(4'hD, 7'h78, 8);
        dwell(4'hB, 7'h00, 8);
        last_dwell(4'h7, 7'h10, 16'h9876, 4'h0);
        // One edge short: digit 0 is not captured, so no frame after digit 3.
        dwell(4'hE, 7'h12, S);
        dwell(4'hD, 7'h79, 8);
        dwell(4'hB, 7'h79, 8);
        dwell(4'h7, 7'h79, 8);
        exp_q.push_back('{v: 16'h1115, e: 4'h0, c: cyc + 1 + S});
        dwell(4'hE, 7'h12, S + 1);
        dwell(4'hF, 7'h7F, 4);

        // Undecodable digit 2.
        dwell(4'hE, 7'h00, 8);
        dwell(4'hD, 7'h00, 8);
        dwell(4'hB, 7'h7F, 8);
        last_dwell(4'h7, 7'h00, 16'h8088, 4'b0100);

        // Blanking and two-digit-low patterns are ignored.
        dwell(4'hE, 7'h40, 8);
        dwell(4'hF, 7'h7F, 5);
        dwell(4'hC, 7'h79, 8);
        dwell(4'hD, 7'h19, 8);
        dwell(4'hF, 7'h7F, 3);
        dwell(4'hB, 7'h02, 8);
        dwell(4'hC, 7'h24, 8);
        dwell(4'hF, 7'h7F, 2);
        last_dwell(4'h7, 7'h78, 16'h7640, 4'h0);

        // Digit 0 recaptured 1 then 5.
        dwell(4'hE, 7'h79, 8);
        dwell(4'hE, 7'h12, 8);
        dwell(4'hD, 7'h21, 8);
        dwell(4'hB, 7'h06, 8);
        last_dwell(4'h7, 7'h0E, 16'hFED5, 4'h0);

        // Reset mid-frame abandons three captured digits.
        dwell(4'hE, 7'h79, 8);
        dwell(4'hD, 7'h79, 8);
        dwell(4'hB, 7'h79, 8);
        rst_n = 1'b0;
        an    = 4'h7;
        seg   = 7'h79;
        @(negedge clk);
        check("midreset_value", {16'd0, value}, 32'd0);
        check("midreset_fv", {31'd0, frame_valid}, 32'd0);
        rst_n = 1'b1;
        dwell(4'hF, 7'h7F, 2);
        dwell(4'hE, 7'h03, 8);
        dwell(4'hD, 7'h08, 8);
        dwell(4'hB, 7'h46, 8);
        last_dwell(4'h7, 7'h10, 16'h9CAB, 4'h0);

        dwell(4'hF, 7'h7F, 6);
        check("pending_frames", exp_q.size(), 32'd0);
        check("held_value", {16'd0, value}, 32'h9CAB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, the number of consecutive stable samples required before a digit is captured (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port seg, input, 7 bits, active-low segment lines: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 SHALL have port an, input, 4 bits, active-low digit enables: an[i]=0 selects digit i.
REQ-006 SHALL have port value, output, 16 bits, last complete frame; digit i occupies value[4i+3:4i].
REQ-007 SHALL have port digit_err, output, 4 bits; bit i=1 means digit i of the last frame held an undecodable pattern.
REQ-008 SHALL have port frame_valid, output, 1 bit, one-cycle pulse when value and digit_err update.

Function
REQ-009 SHALL register (an,seg) every cycle into a previous-sample register, and keep a saturating stability counter.
REQ-010 SHALL clear the counter on any edge where (an,seg) differs from the previous sample, and increment it otherwise, saturating at SETTLE_CYCLES.
REQ-011 SHALL use a two-state machine, WAIT and HOLD; reset enters WAIT.
REQ-012 In WAIT, the block SHALL capture on the SETTLE_CYCLES-th consecutive edge at which (an,seg) equals the previous sample, provided an has exactly one bit low; it then enters HOLD.
REQ-013 In HOLD, the block SHALL perform no capture and SHALL return to WAIT on the first edge where (an,seg) changes; each dwell is therefore captured at most once.
REQ-014 SHALL ignore, without capturing, inputs where an=4'hF (blanking) or more than one an bit is low; the counter still runs and the state stays WAIT.
REQ-015 SHALL decode seg to a nibble using these exact active-low codes:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex)
REQ-016 SHALL capture any seg code not in the REQ-015 table as nibble 0 with its shadow error bit set to 1; a valid code clears that bit.
REQ-017 SHALL write each capture into a shadow nibble and a shadow error bit for digit i, and set seen[i].
REQ-018 SHALL overwrite the shadow nibble and error bit of an already-seen digit on recapture, leaving seen unchanged.
REQ-019 On the edge that makes seen=4'hF, SHALL copy the shadow contents, including that edge's capture, into value and digit_err, pulse frame_valid high for exactly that one cycle, and clear seen.
REQ-020 SHALL hold value and digit_err constant between frame_valid pulses.
REQ-021 SHALL have a latency of 0 extra cycles: frame_valid is asserted in the cycle immediately after the capturing edge of the final digit.
REQ-022 SHALL not assert frame_valid on consecutive cycles, because each frame needs four captures, each requiring at least one stable edge.

Reset
REQ-023 On rst_n=0 at a rising edge, SHALL set value=0, digit_err=0, frame_valid=0, seen=0, shadow=0, counter=0, previous sample=all ones, state=WAIT.
REQ-024 SHALL abandon any partially collected frame when reset occurs mid-frame; no frame_valid is issued for it after reset.
REQ-025 SHALL hold all outputs at their reset values while rst_n=0, regardless of the seg and an activity.

Verification
REQ-026 The bench SHALL drive a scan of an=E,D,B,7 with seg=79,24,30,19, each held for 8 cycles, and SHALL require value=16'h4321, digit_err=0, and one frame_valid pulse.
REQ-027 The bench SHALL drive a digit 0 dwell of exactly SETTLE_CYCLES stable edges, then the same with one fewer, and SHALL require a capture in the first case only.
REQ-028 The bench SHALL drive digit 2 with seg=7F (blank/invalid) inside an otherwise valid scan of 8,8,x,8, and SHALL require value=16'h8088 and digit_err=4'b0100.
REQ-029 The bench SHALL insert an=F blanking between dwells and an=C (two digits low) dwells, and SHALL require no capture for those and unchanged frame timing otherwise.
REQ-030 The bench SHALL capture digit 0 as 1 then 5 before the rest of the scan (F,E,d), and SHALL require value=16'hFED5.
REQ-031 The bench SHALL assert rst_n=0 for one cycle after three digits are captured, then complete a fresh full scan, and SHALL require frame_valid only after all four new digits are captured.
